fault_event_generator: RTL and testbench
========================================

Name: fault_event_generator

Overview:
- Producer side of the status-event interface consumed by the LED driver.
- Debounces the raw fault sensor and tracks the run sequence: scan → fault found → block picked → block dropped → return to start.
- Emits single-cycle pulses: fault_detect, EU/CU/RU_fault_flag, run_complete.
- Sits between the sensor/path-planner logic and the LED driver, all in the clk_50M domain.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive stable synchronised samples needed to accept a sensor level change (1 ms at 50 MHz)
MAX_FAULTS, 3, number of units (EU, CU, RU); run ends after this many faults are dropped

Ports:
clk_50M  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous active-low reset
switch_key  input  1  run enable; low aborts the run and returns to IDLE
fault_sense_raw  input  1  raw fault sensor, asynchronous, active-high
unit_sel  input  2  current unit: 0 = none, 1 = EU, 2 = CU, 3 = RU
block_picked  input  1  single-cycle pulse, pick complete
object_drop  input  1  single-cycle pulse, drop complete
at_start_node  input  1  level, robot is at the start node
fault_detect  output  1  single-cycle pulse, new fault accepted
EU_fault_flag  output  1  single-cycle pulse with fault_detect when unit_sel = 1
CU_fault_flag  output  1  single-cycle pulse with fault_detect when unit_sel = 2
RU_fault_flag  output  1  single-cycle pulse with fault_detect when unit_sel = 3
run_complete  output  1  single-cycle pulse on arrival at start after all drops
busy  output  1  high in FAULT or CARRY
reported  output  3  sticky per-unit mask {RU, CU, EU}
state_dbg  output  3  FSM state encoding

Behaviour:
- Reset (rst_n low, async): all outputs 0; FSM = IDLE; reported = 0; drop count = 0; debounce counter = 0; debounced level = 0; sync flops = 0.
- Sensor path:
  - 2-FF synchroniser.
  - Debounce counter, width $clog2(DEBOUNCE_CYCLES+1): clears whenever the synchronised sample equals the debounced level; otherwise increments.
  - Debounced level toggles when the counter reaches DEBOUNCE_CYCLES−1; the counter clears in the same cycle.
  - rise = one-cycle strobe on a debounced 0→1 transition.
- Latency: raw edge → rise is 2 + DEBOUNCE_CYCLES cycles. rise → fault pulses is 1 cycle (registered outputs).
- FSM states: IDLE, SCAN, FAULT, CARRY, RETURN, DONE.
  - IDLE: switch_key high → SCAN.
  - SCAN: accept when rise && unit_sel != 0 && !reported[unit_sel−1]. On accept, next cycle:
    - pulse fault_detect and the matching unit flag;
    - set the reported bit;
    - FSM → FAULT.
  - SCAN ignore cases: rise with unit_sel = 0, or with the unit already reported → no pulse, stay in SCAN.
  - FAULT: block_picked → CARRY. object_drop alone is ignored.
  - CARRY: object_drop → increment drop count. If the new count == MAX_FAULTS → RETURN, else → SCAN.
  - RETURN: at_start_node high → pulse run_complete next cycle, FSM → DONE.
  - DONE: hold; run_complete is not repeated. switch_key low → IDLE.
- switch_key low in any state except IDLE, synchronously:
  - FSM → IDLE;
  - reported and drop count clear;
  - pulses already scheduled for the next cycle are suppressed.
- Simultaneous events:
  - block_picked and object_drop together in FAULT → picked only; the drop is lost.
  - rise while in FAULT/CARRY/RETURN/DONE → ignored, not queued.
  - rise and switch_key falling edge in the same cycle → abort wins, no pulse.
- The debouncer runs in all states, including IDLE, so a sensor held high at run start does not produce a rise.
- No output pulse is ever wider than one cycle.
- reset mid-operation → immediate return to reset values, including outputs mid-pulse.

Decomposition:
- Shared package holds:
  - state encodings IDLE = 0, SCAN = 1, FAULT = 2, CARRY = 3, RETURN = 4, DONE = 5 (shared with state_dbg decode in the LED driver bench);
  - unit codes UNIT_NONE, UNIT_EU, UNIT_CU, UNIT_RU.
- Sub-module sensor_debouncer (synchroniser + counter + rise strobe), parameterised by DEBOUNCE_CYCLES and reusable for the other sensor inputs.

Test Plan (DEBOUNCE_CYCLES = 4):
1. Reset then switch_key = 1, unit_sel = 1, sensor high for 10 cycles → exactly one fault_detect + EU_fault_flag pulse 7 cycles after the edge; reported = 001; state_dbg = 2.
2. Sensor glitch high for 3 cycles in SCAN → no pulse; state stays SCAN.
3. Full run:
   - faults on units 1, 2, 3, each followed by block_picked then object_drop;
   - then at_start_node = 1;
   - → three fault pulses with the matching unit flags; one run_complete pulse; state_dbg = 5; no further pulses while at_start_node stays high.
4. Repeat fault on unit 2 after it has been reported, and a fault with unit_sel = 0 → no pulses; reported unchanged.
5. block_picked and object_drop in the same cycle in FAULT → CARRY; drop count unchanged. A later object_drop → SCAN.
6. switch_key low in CARRY, then high → IDLE then SCAN; reported = 000; a unit 1 fault is accepted again. Separately, rst_n low mid-pulse → outputs 0 asynchronously.

Source files
------------

// File: rtl/fault_event_generator_pkg.sv
// fault_event_generator_pkg: shared FSM state encoding, unit codes and unit mask helper
package fault_event_generator_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SCAN   = 3'd1,
    FAULT  = 3'd2,
    CARRY  = 3'd3,
    RETURN = 3'd4,
    DONE   = 3'd5
  } state_e;
  localparam logic [1:0] UNIT_NONE = 2'd0;
  localparam logic [1:0] UNIT_EU   = 2'd1;
  localparam logic [1:0] UNIT_CU   = 2'd2;
  localparam logic [1:0] UNIT_RU   = 2'd3;
  function automatic logic [2:0] unit_mask(input logic [1:0] u);
    return (u == UNIT_NONE) ? 3'b000 : 3'(1 << (u - 2'd1));
  endfunction
endpackage

// File: rtl/sensor_debouncer.sv
// sensor_debouncer: 2-FF synchroniser, stability counter and one-cycle rising-edge strobe
module sensor_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic level;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      rise <= 1'b0;
      if (sync[1] == level) cnt <= '0;
      else if (cnt == LAST) begin
        cnt   <= '0;
        level <= ~level;
        rise  <= ~level;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/fault_event_generator.sv
// fault_event_generator: debounced fault sensing and run sequencing that emits single-cycle status pulses
module fault_event_generator
  import fault_event_generator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int MAX_FAULTS      = 3
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       switch_key,
  input  logic       fault_sense_raw,
  input  logic [1:0] unit_sel,
  input  logic       block_picked,
  input  logic       object_drop,
  input  logic       at_start_node,
  output logic       fault_detect,
  output logic       EU_fault_flag,
  output logic       CU_fault_flag,
  output logic       RU_fault_flag,
  output logic       run_complete,
  output logic       busy,
  output logic [2:0] reported,
  output logic [2:0] state_dbg
);
  localparam int DW = $clog2(MAX_FAULTS + 1);
  state_e state, state_n;
  logic [2:0] rep_n, mask;
  logic [DW-1:0] drops, drops_n;
  logic [4:0] pulse_n;
  logic rise;
  sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk  (clk_50M),
    .rst_n(rst_n),
    .raw  (fault_sense_raw),
    .rise (rise)
  );
  assign mask      = unit_mask(unit_sel);
  assign busy      = (state == FAULT) || (state == CARRY);
  assign state_dbg = state;
  // pulse_n packs {run_complete, RU, CU, EU, fault_detect}; abort overrides any event this cycle
  always_comb begin
    state_n = state;
    rep_n   = reported;
    drops_n = drops;
    pulse_n = '0;
    if (state != IDLE && !switch_key) begin
      state_n = IDLE;
      rep_n   = '0;
      drops_n = '0;
    end else begin
      case (state)
        IDLE: state_n = switch_key ? SCAN : IDLE;
        SCAN: if (rise && mask != 3'b000 && (mask & reported) == 3'b000) begin
          state_n = FAULT;
          rep_n   = reported | mask;
          pulse_n = {1'b0, mask, 1'b1};
        end
        FAULT: state_n = block_picked ? CARRY : FAULT;
        CARRY: if (object_drop) begin
          drops_n = drops + 1'b1;
          state_n = (drops_n == DW'(MAX_FAULTS)) ? RETURN : SCAN;
        end
        RETURN: if (at_start_node) begin
          state_n = DONE;
          pulse_n = 5'b10000;
        end
        default: state_n = state;
      endcase
    end
  end
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      reported <= '0;
      drops    <= '0;
      {run_complete, RU_fault_flag, CU_fault_flag, EU_fault_flag, fault_detect} <= '0;
    end else begin
      state    <= state_n;
      reported <= rep_n;
      drops    <= drops_n;
      {run_complete, RU_fault_flag, CU_fault_flag, EU_fault_flag, fault_detect} <= pulse_n;
    end
  end
endmodule

// File: tb/tb_fault_event_generator.sv
// tb_fault_event_generator: scoreboard bench with a behavioural run model and randomized stimulus
module tb_fault_event_generator;
  localparam int D = 4;
  localparam int S_IDLE = 0, S_SCAN = 1, S_FAULT = 2, S_CARRY = 3, S_RETURN = 4, S_DONE = 5;
  logic clk_50M = 0, rst_n = 0, switch_key = 0, fault_sense_raw = 0;
  logic block_picked = 0, object_drop = 0, at_start_node = 0;
  logic [1:0] unit_sel = 0;
  logic fault_detect, EU_fault_flag, CU_fault_flag, RU_fault_flag, run_complete, busy;
  logic [2:0] reported, state_dbg;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {int c; logic [4:0] v;} ev_t;
  ev_t q[$];
  int m_st, m_drops, m_run;
  logic [2:0] m_rep;
  logic m_lvl, m_rise;
  logic hist[$];

  fault_event_generator #(.DEBOUNCE_CYCLES(D), .MAX_FAULTS(3)) dut (
    .clk_50M(clk_50M), .rst_n(rst_n), .switch_key(switch_key), .fault_sense_raw(fault_sense_raw),
    .unit_sel(unit_sel), .block_picked(block_picked), .object_drop(object_drop),
    .at_start_node(at_start_node), .fault_detect(fault_detect), .EU_fault_flag(EU_fault_flag),
    .CU_fault_flag(CU_fault_flag), .RU_fault_flag(RU_fault_flag), .run_complete(run_complete),
    .busy(busy), .reported(reported), .state_dbg(state_dbg)
  );

  always #10 clk_50M = ~clk_50M;

  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_st = S_IDLE; m_drops = 0; m_run = 0; m_rep = 0; m_lvl = 0; m_rise = 0;
    hist.delete();
  endtask

  // Expected outputs after the coming clock edge, from the run rules and the sensor stability rule
  task automatic model_update();
    logic [4:0] p;
    logic s;
    int u;
    p = 0;
    u = unit_sel;
    if (m_st != S_IDLE && !switch_key) begin
      m_st = S_IDLE; m_rep = 0; m_drops = 0;
    end else if (m_st == S_IDLE) begin
      if (switch_key) m_st = S_SCAN;
    end else if (m_st == S_SCAN) begin
      if (m_rise && u != 0 && !m_rep[u-1]) begin
        m_rep[u-1] = 1'b1;
        p = 5'b00001 | 5'(1 << u);
        m_st = S_FAULT;
      end
    end else if (m_st == S_FAULT) begin
      if (block_picked) m_st = S_CARRY;
    end else if (m_st == S_CARRY) begin
      if (object_drop) begin
        m_drops++;
        m_st = (m_drops == 3) ? S_RETURN : S_SCAN;
      end
    end else if (m_st == S_RETURN) begin
      if (at_start_node) begin
        p = 5'b10000;
        m_st = S_DONE;
      end
    end
    // the synchronised sample seen at this edge is the raw value from two edges back
    s = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
    hist.push_back(fault_sense_raw);
    if (hist.size() > 3) void'(hist.pop_front());
    m_rise = 1'b0;
    if (s != m_lvl) begin
      m_run++;
      if (m_run == D) begin
        m_lvl = ~m_lvl;
        m_run = 0;
        m_rise = m_lvl;
      end
    end else m_run = 0;
    if (p != 0) q.push_back('{c: cyc + 1, v: p});
  endtask

  task automatic step();
    model_update();
    @(posedge clk_50M);
    cyc++;
    @(negedge clk_50M);
  endtask

  task automatic check_state(string tag);
    chk({tag, "_state"}, state_dbg, m_st);
    chk({tag, "_reported"}, reported, m_rep);
    chk({tag, "_busy"}, busy, (m_st == S_FAULT || m_st == S_CARRY));
  endtask

  task automatic chk_zero(string n);
    chk(n, {fault_detect, EU_fault_flag, CU_fault_flag, RU_fault_flag, run_complete, busy, reported, state_dbg}, 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    #3;
    chk_zero("reset_outputs");
    model_reset();
    q.delete();
    @(negedge clk_50M);
    rst_n = 1;
  endtask

  task automatic fault(int u, int n);
    unit_sel = 2'(u);
    fault_sense_raw = 1;
    repeat (n) step();
    fault_sense_raw = 0;
    repeat (8) step();
  endtask

  task automatic pickdrop();
    block_picked = 1; step(); block_picked = 0; step();
    object_drop = 1; step(); object_drop = 0; step();
  endtask

  always @(negedge clk_50M) begin : mon
    logic [4:0] obs;
    if (rst_n) begin
      obs = {run_complete, RU_fault_flag, CU_fault_flag, EU_fault_flag, fault_detect};
      while (q.size() > 0 && q[0].c < cyc) begin
        checks++; errors++;
        $display("FAIL missing_pulse cycle %0d want %b got none", q[0].c, q[0].v);
        void'(q.pop_front());
      end
      if (obs != 0) begin
        checks++;
        if (q.size() == 0 || q[0].c != cyc || q[0].v != obs) begin
          errors++;
          $display("FAIL pulse cycle %0d got %b want %b", cyc, obs,
                   (q.size() > 0 && q[0].c == cyc) ? q[0].v : 5'b0);
        end
        if (q.size() > 0 && q[0].c == cyc) void'(q.pop_front());
      end
    end
  end

  initial begin
    int c0, seen, n_rc;
    logic hit;
    model_reset();
    @(negedge clk_50M);
    do_reset();
    check_state("reset");
    // single fault: latency and reported bit
    switch_key = 1; unit_sel = 1; step();
    c0 = cyc; seen = -1;
    fault_sense_raw = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (fault_detect && EU_fault_flag && seen < 0) seen = cyc;
    end
    fault_sense_raw = 0;
    repeat (8) step();
    chk("latency", seen - c0, 7);
    chk("t1_reported", reported, 3'b001);
    chk("t1_state", state_dbg, S_FAULT);
    // glitch in SCAN
    pickdrop();
    fault(1, 3);
    chk("glitch_state", state_dbg, S_SCAN);
    check_state("glitch");
    // full run
    fault(2, 8); pickdrop();
    fault(3, 8); pickdrop();
    chk("return_state", state_dbg, S_RETURN);
    at_start_node = 1;
    n_rc = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (run_complete) n_rc++;
    end
    at_start_node = 0;
    chk("run_complete_count", n_rc, 1);
    chk("done_state", state_dbg, S_DONE);
    check_state("done");
    // repeat fault and unit 0
    switch_key = 0; step();
    chk("abort_idle", state_dbg, S_IDLE);
    switch_key = 1; step();
    fault(2, 8); pickdrop();
    fault(2, 8);
    fault(0, 8);
    chk("repeat_reported", reported, 3'b010);
    chk("repeat_state", state_dbg, S_SCAN);
    // simultaneous pick and drop
    fault(1, 8);
    block_picked = 1; object_drop = 1; step();
    block_picked = 0; object_drop = 0; step();
    chk("simul_state", state_dbg, S_CARRY);
    object_drop = 1; step(); object_drop = 0; step();
    chk("after_drop_state", state_dbg, S_SCAN);
    // abort in CARRY then restart
    fault(3, 8);
    block_picked = 1; step(); block_picked = 0; step();
    chk("carry_state", state_dbg, S_CARRY);
    switch_key = 0; step();
    chk("abort_state", state_dbg, S_IDLE);
    chk("abort_reported", reported, 0);
    switch_key = 1; step();
    fault(1, 8);
    chk("restart_reported", reported, 3'b001);
    check_state("restart");
    pickdrop();
    // reset while a pulse is on the outputs
    unit_sel = 2; fault_sense_raw = 1; hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step();
      hit = fault_detect;
    end
    chk("midpulse_seen", hit, 1);
    #2;
    do_reset();
    fault_sense_raw = 0; unit_sel = 0;
    step();
    check_state("post_reset");
    // randomized run traffic
    for (int i = 0; i < 3000; i++) begin
      switch_key = ($urandom_range(199) != 0);
      if ($urandom_range(9) == 0) fault_sense_raw = ~fault_sense_raw;
      unit_sel = 2'($urandom_range(3));
      block_picked = ($urandom_range(5) == 0);
      object_drop = ($urandom_range(5) == 0);
      at_start_node = ($urandom_range(7) == 0);
      step();
      check_state("rand");
    end
    block_picked = 0; object_drop = 0; at_start_node = 0; fault_sense_raw = 0;
    repeat (5) step();
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
